// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin two-writer/one-reader controller for a shared 16-entry memory,
// with a flush mode that drains all stored words before new writes are accepted.
module fifo_share_ctrl #(
    parameter int DATA_W = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_req1,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              wr_ack0,
    output logic              wr_ack1,
    input  logic              rd_req,
    input  logic              flush,
    output logic              rd_valid,
    output logic              draining,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_wrAddress,
    output logic [ADDR_W-1:0] mem_rdAddress,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              rr_last, start, can_wr, g0, g1;

    always_comb begin
        full          = count == (ADDR_W + 1)'(DEPTH);
        empty         = count == '0;
        draining      = state == DRAIN;
        // an accepted flush already blocks writes in its own cycle
        start         = state == RUN && flush && !empty;
        can_wr        = state == RUN && !start && !full;
        g0            = can_wr && wr_req0 && (!wr_req1 || rr_last);
        g1            = can_wr && wr_req1 && (!wr_req0 || !rr_last);
        wr_ack0       = g0;
        wr_ack1       = g1;
        mem_wen       = g0 || g1;
        mem_dataIn    = g0 ? wr_data0 : g1 ? wr_data1 : '0;
        mem_ren       = !empty && (draining || rd_req);
        mem_wrAddress = wr_ptr;
        mem_rdAddress = rd_ptr;
        count_nxt     = count + (ADDR_W + 1)'(mem_wen) - (ADDR_W + 1)'(mem_ren);
        state_nxt     = start ? DRAIN : (draining && count_nxt == '0) ? RUN : state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr_last  <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            rd_valid <= mem_ren;
            if (mem_wen) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (mem_ren) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_req0 && wr_req1 && mem_wen) rr_last <= g1;
        end
    end
endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb_fifo_share_ctrl: directed and randomized checks of fifo_share_ctrl against a queue-based model
// plus a behavioural memory so read data order is verified end to end.
module tb_fifo_share_ctrl;
    localparam int DW = 15;
    localparam int AW = 4;

    logic clock = 0, reset = 1, wr_req0 = 0, wr_req1 = 0, rd_req = 0, flush = 0;
    logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
    logic wr_ack0, wr_ack1, rd_valid, draining, mem_wen, mem_ren, full, empty;
    logic [AW-1:0] mem_wrAddress, mem_rdAddress;
    logic [DW-1:0] mem_dataIn;
    logic [AW:0]   count;

    always #5 clock = ~clock;

    fifo_share_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .wr_req0(wr_req0), .wr_data0(wr_data0), .wr_req1(wr_req1), .wr_data1(wr_data1),
        .wr_ack0(wr_ack0), .wr_ack1(wr_ack1), .rd_req(rd_req), .flush(flush),
        .rd_valid(rd_valid), .draining(draining), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_wrAddress(mem_wrAddress), .mem_rdAddress(mem_rdAddress), .mem_dataIn(mem_dataIn),
        .full(full), .empty(empty), .count(count)
    );

    // memory_unit stand-in with one-cycle registered read
    logic [DW-1:0] mem [16];
    logic [DW-1:0] dout;
    always @(posedge clock) begin
        if (mem_wen) mem[mem_wrAddress] <= mem_dataIn;
        if (mem_ren) dout <= mem[mem_rdAddress];
    end

    logic [DW-1:0] q[$];
    int m_wp = 0, m_rp = 0, e_cnt = 0;
    bit m_last = 1, m_drain = 0, m_rv = 0;
    logic [DW-1:0] m_rdata = '0;
    bit e_full, e_empty, e_ren, e_start, e_g0, e_g1;
    int n_pass = 0, n_total = 0;

    task automatic eval();
        @(negedge clock);
        e_cnt   = q.size();
        e_full  = e_cnt == 16;
        e_empty = e_cnt == 0;
        e_ren   = !e_empty && (m_drain || rd_req);
        e_start = !m_drain && flush && !e_empty;
        e_g0 = 0;
        e_g1 = 0;
        if (!m_drain && !e_start && !e_full) begin
            if (wr_req0 && wr_req1) begin
                e_g0 = m_last;
                e_g1 = !m_last;
            end else begin
                e_g0 = wr_req0;
                e_g1 = wr_req1;
            end
        end
    endtask

    task automatic adv();
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_wp = 0; m_rp = 0; m_last = 1; m_drain = 0; m_rv = 0;
        end else begin
            m_rv = e_ren;
            if (e_ren) begin
                m_rdata = q.pop_front();
                m_rp = (m_rp + 1) % 16;
            end
            if (e_g0 || e_g1) begin
                q.push_back(e_g0 ? wr_data0 : wr_data1);
                m_wp = (m_wp + 1) % 16;
                if (wr_req0 && wr_req1) m_last = e_g1;
            end
            if (e_start) m_drain = 1;
            else if (m_drain && q.size() == 0) m_drain = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; wr_req0 = 0; wr_req1 = 0; rd_req = 0; flush = 0;
        repeat (2) begin eval(); adv(); end
        reset = 0;
    endtask

    task automatic fill(input int n);
        wr_req0 = 1;
        for (int i = 0; i < n; i++) begin
            wr_data0 = DW'($urandom);
            eval(); adv();
        end
        wr_req0 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        eval();
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty, full); else n_pass++;
        n_total++; if ({draining, rd_valid, mem_wen, mem_ren, wr_ack0, wr_ack1} !== 6'b0)
            $display("FAIL reset_outs got %b exp 000000", {draining, rd_valid, mem_wen, mem_ren, wr_ack0, wr_ack1}); else n_pass++;
        n_total++; if ({mem_wrAddress, mem_rdAddress} !== 8'h00) $display("FAIL reset_ptrs got %h exp 00", {mem_wrAddress, mem_rdAddress}); else n_pass++;
        adv();
    endtask

    task automatic test_single();
        do_reset();
        wr_req0 = 1; wr_data0 = 15'h1234;
        eval();
        n_total++; if ({wr_ack0, wr_ack1, mem_wen} !== 3'b101) $display("FAIL single_ack got %b exp 101", {wr_ack0, wr_ack1, mem_wen}); else n_pass++;
        n_total++; if (mem_wrAddress !== 4'd0 || mem_dataIn !== 15'h1234) $display("FAIL single_wr got a=%0d d=%h exp a=0 d=1234", mem_wrAddress, mem_dataIn); else n_pass++;
        adv();
        wr_req0 = 0;
        eval();
        n_total++; if (count !== 5'd1 || empty !== 1'b0 || wr_ack0 !== 1'b0) $display("FAIL single_cnt got c=%0d e=%b ack=%b exp 1 0 0", count, empty, wr_ack0); else n_pass++;
        adv();
        rd_req = 1;
        eval();
        n_total++; if (mem_ren !== 1'b1 || mem_rdAddress !== 4'd0) $display("FAIL single_rd got ren=%b a=%0d exp 1 0", mem_ren, mem_rdAddress); else n_pass++;
        adv();
        rd_req = 0;
        eval();
        n_total++; if (rd_valid !== 1'b1 || dout !== 15'h1234) $display("FAIL single_data got v=%b d=%h exp 1 1234", rd_valid, dout); else n_pass++;
        n_total++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL single_empty got c=%0d e=%b exp 0 1", count, empty); else n_pass++;
        adv();
    endtask

    task automatic test_alternate();
        do_reset();
        wr_req0 = 1; wr_req1 = 1;
        for (int i = 0; i < 6; i++) begin
            wr_data0 = DW'(i); wr_data1 = DW'(i + 100);
            eval();
            n_total++; if ({wr_ack0, wr_ack1} !== (i % 2 == 0 ? 2'b10 : 2'b01) || mem_wrAddress !== 4'(i))
                $display("FAIL alt_%0d got ack=%b a=%0d exp ack=%b a=%0d", i, {wr_ack0, wr_ack1}, mem_wrAddress, (i % 2 == 0 ? 2'b10 : 2'b01), i); else n_pass++;
            adv();
        end
        wr_req0 = 0; wr_req1 = 0;
        eval();
        n_total++; if (count !== 5'd6) $display("FAIL alt_count got %0d exp 6", count); else n_pass++;
        adv();
    endtask

    task automatic test_full();
        do_reset();
        fill(16);
        eval();
        n_total++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL full_flag got f=%b c=%0d exp 1 16", full, count); else n_pass++;
        adv();
        wr_req1 = 1; wr_data1 = 15'h7abc;
        repeat (2) begin
            eval();
            n_total++; if (wr_ack1 !== 1'b0 || mem_wen !== 1'b0) $display("FAIL full_block got ack=%b wen=%b exp 0 0", wr_ack1, mem_wen); else n_pass++;
            adv();
        end
        rd_req = 1;
        eval();
        n_total++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) $display("FAIL full_rd got ren=%b wen=%b exp 1 0", mem_ren, mem_wen); else n_pass++;
        adv();
        rd_req = 0;
        eval();
        n_total++; if (count !== 5'd15 || wr_ack1 !== 1'b1 || mem_wrAddress !== 4'd0)
            $display("FAIL full_wrap got c=%0d ack=%b a=%0d exp 15 1 0", count, wr_ack1, mem_wrAddress); else n_pass++;
        adv();
        wr_req1 = 0;
        eval();
        n_total++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL full_refill got c=%0d f=%b exp 16 1", count, full); else n_pass++;
        adv();
    endtask

    task automatic test_simul();
        do_reset();
        fill(5);
        wr_req0 = 1; rd_req = 1; wr_data0 = 15'h0abc;
        eval();
        n_total++; if ({mem_wen, mem_ren} !== 2'b11 || mem_wrAddress !== 4'd5 || mem_rdAddress !== 4'd0)
            $display("FAIL simul_both got wen/ren=%b wa=%0d ra=%0d exp 11 5 0", {mem_wen, mem_ren}, mem_wrAddress, mem_rdAddress); else n_pass++;
        adv();
        wr_req0 = 0; rd_req = 0;
        eval();
        n_total++; if (count !== 5'd5 || mem_wrAddress !== 4'd6 || mem_rdAddress !== 4'd1)
            $display("FAIL simul_after got c=%0d wa=%0d ra=%0d exp 5 6 1", count, mem_wrAddress, mem_rdAddress); else n_pass++;
        adv();
    endtask

    task automatic test_drain();
        int rds = 0;
        bit done = 0;
        do_reset();
        fill(4);
        rd_req = 1; eval(); adv(); rd_req = 0;
        flush = 1; wr_req0 = 1; wr_data0 = 15'h0055;
        eval();
        n_total++; if (wr_ack0 !== 1'b0) $display("FAIL drain_flushcyc got ack=%b exp 0", wr_ack0); else n_pass++;
        adv();
        flush = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            eval();
            if (!draining) done = 1;
            else begin
                n_total++; if (mem_ren !== 1'b1 || mem_rdAddress !== 4'(1 + rds) || wr_ack0 !== 1'b0)
                    $display("FAIL drain_rd%0d got ren=%b a=%0d ack=%b exp 1 %0d 0", rds, mem_ren, mem_rdAddress, wr_ack0, 1 + rds); else n_pass++;
                rds++;
                adv();
            end
        end
        n_total++; if (rds != 3 || !done) $display("FAIL drain_len got %0d reads done=%b exp 3 1", rds, done); else n_pass++;
        n_total++; if (count !== 5'd0 || wr_ack0 !== 1'b1) $display("FAIL drain_exit got c=%0d ack=%b exp 0 1", count, wr_ack0); else n_pass++;
        adv();
        wr_req0 = 0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fill(4);
        flush = 1; eval(); adv(); flush = 0;
        eval();
        n_total++; if (draining !== 1'b1) $display("FAIL mid_drain got %b exp 1", draining); else n_pass++;
        adv();
        reset = 1;
        eval(); adv();
        reset = 0;
        eval();
        n_total++; if ({draining, rd_valid, empty, count} !== {3'b001, 5'd0})
            $display("FAIL mid_reset got d=%b v=%b e=%b c=%0d exp 0 0 1 0", draining, rd_valid, empty, count); else n_pass++;
        n_total++; if ({mem_wrAddress, mem_rdAddress} !== 8'h00) $display("FAIL mid_ptrs got %h exp 00", {mem_wrAddress, mem_rdAddress}); else n_pass++;
        adv();
        flush = 1; eval(); adv(); flush = 0;
        eval();
        n_total++; if (draining !== 1'b0) $display("FAIL empty_flush got %b exp 0", draining); else n_pass++;
        adv();
    endtask

    task automatic test_random();
        logic [20:0] exp_v, act_v;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (!wr_req0 && $urandom_range(2) == 0) begin wr_req0 = 1; wr_data0 = DW'($urandom); end
            if (!wr_req1 && $urandom_range(2) == 0) begin wr_req1 = 1; wr_data1 = DW'($urandom); end
            rd_req = (i % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            flush  = $urandom_range(39) == 0;
            reset  = $urandom_range(249) == 0;
            eval();
            if (!reset) begin
                exp_v = {e_g0, e_g1, e_g0 | e_g1, e_ren, 4'(m_wp), 4'(m_rp), m_drain, e_full, e_empty, 5'(e_cnt), m_rv};
                act_v = {wr_ack0, wr_ack1, mem_wen, mem_ren, mem_wrAddress, mem_rdAddress, draining, full, empty, count, rd_valid};
                n_total++; if (act_v !== exp_v) $display("FAIL rand_outs cyc %0d got %h exp %h", i, act_v, exp_v); else n_pass++;
                if (e_g0 || e_g1) begin
                    n_total++; if (mem_dataIn !== (e_g0 ? wr_data0 : wr_data1))
                        $display("FAIL rand_din cyc %0d got %h exp %h", i, mem_dataIn, (e_g0 ? wr_data0 : wr_data1)); else n_pass++;
                end
                if (m_rv) begin
                    n_total++; if (dout !== m_rdata) $display("FAIL rand_dout cyc %0d got %h exp %h", i, dout, m_rdata); else n_pass++;
                end
            end
            adv();
            if (!reset && e_g0) wr_req0 = 0;
            if (!reset && e_g1) wr_req1 = 0;
        end
        reset = 0; wr_req0 = 0; wr_req1 = 0; rd_req = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_simul();
        test_drain();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
